// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between the register-file write-port arbiter and its pipeline/MDU neighbours.
// The slave modport is the arbiter's view; the master modport is the surrounding pipeline's view.
interface wb_port_arbiter_if #(
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          pipe_RegWrite_in;
    logic [4:0]    pipe_DestReg_in;
    logic [31:0]   pipe_data_in;
    logic          mdu_valid_in;
    logic [4:0]    mdu_DestReg_in;
    logic [31:0]   mdu_data_in;
    logic          mdu_ready_out;
    logic          rf_we_out;
    logic [4:0]    rf_waddr_out;
    logic [31:0]   rf_wdata_out;
    logic          bubble_req_out;
    logic [CW-1:0] fifo_count_out;

    modport master (
        output pipe_RegWrite_in, pipe_DestReg_in, pipe_data_in,
        output mdu_valid_in, mdu_DestReg_in, mdu_data_in,
        input  mdu_ready_out, rf_we_out, rf_waddr_out, rf_wdata_out,
        input  bubble_req_out, fifo_count_out
    );

    modport slave (
        input  pipe_RegWrite_in, pipe_DestReg_in, pipe_data_in,
        input  mdu_valid_in, mdu_DestReg_in, mdu_data_in,
        output mdu_ready_out, rf_we_out, rf_waddr_out, rf_wdata_out,
        output bubble_req_out, fifo_count_out
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback wins, MDU results queue in a FIFO and drain
// on free cycles. Optional same-cycle MDU bypass into an idle port is enabled by WB_MDU_BYPASS_EN.
module wb_port_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic             clk,
    input  logic             rst,
    wb_port_arbiter_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(STARVE_LIMIT);

    logic [4:0]       mem_dest_r [DEPTH];
    logic [31:0]      mem_data_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [CNT_W-1:0] starve_cnt_r;
    logic             bubble_r;

    logic        pw_s;
    logic        empty_s;
    logic        ready_s;
    logic        accept_s;
    logic        pop_s;
    logic        push_s;
    logic        bypass_s;
    logic        we_s;
    logic [4:0]  waddr_s;
    logic [31:0] wdata_s;

    // Per-cycle grant, pop and push decisions; outputs are forced quiet while reset is held
    always_comb begin
        pw_s     = bus.pipe_RegWrite_in && (bus.pipe_DestReg_in != 5'd0);
        empty_s  = (count_r == {CW{1'b0}});
        ready_s  = rst && (count_r < FULL_CNT);
        accept_s = bus.mdu_valid_in && ready_s;
        pop_s    = !pw_s && !empty_s;
`ifdef WB_MDU_BYPASS_EN
        bypass_s = !pw_s && empty_s && bus.mdu_valid_in && (bus.mdu_DestReg_in != 5'd0);
`else
        bypass_s = 1'b0;
`endif
        // r0 results are swallowed; bypassed results never occupy a slot
        push_s   = accept_s && (bus.mdu_DestReg_in != 5'd0) && !bypass_s;
        we_s     = 1'b0;
        waddr_s  = 5'd0;
        wdata_s  = 32'd0;
        if (!rst) begin
            we_s    = 1'b0;
            waddr_s = 5'd0;
            wdata_s = 32'd0;
        end else if (pw_s) begin
            we_s    = 1'b1;
            waddr_s = bus.pipe_DestReg_in;
            wdata_s = bus.pipe_data_in;
        end else if (!empty_s) begin
            we_s    = 1'b1;
            waddr_s = mem_dest_r[rd_ptr_r];
            wdata_s = mem_data_r[rd_ptr_r];
        end else if (bypass_s) begin
            we_s    = 1'b1;
            waddr_s = bus.mdu_DestReg_in;
            wdata_s = bus.mdu_data_in;
        end else begin
            we_s    = 1'b0;
            waddr_s = 5'd0;
            wdata_s = 32'd0;
        end
    end

    // FIFO storage, pointers, occupancy, starvation counter and bubble request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_dest_r[i] <= 5'd0;
                mem_data_r[i] <= 32'd0;
            end
            wr_ptr_r     <= {AW{1'b0}};
            rd_ptr_r     <= {AW{1'b0}};
            count_r      <= {CW{1'b0}};
            starve_cnt_r <= {CNT_W{1'b0}};
            bubble_r     <= 1'b0;
        end else begin
            if (push_s) begin
                mem_dest_r[wr_ptr_r] <= bus.mdu_DestReg_in;
                mem_data_r[wr_ptr_r] <= bus.mdu_data_in;
                wr_ptr_r             <= wr_ptr_r + AW'(1'b1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
            // A non-empty FIFO that does not pop this cycle was denied by the pipeline
            if (empty_s || pop_s) begin
                starve_cnt_r <= {CNT_W{1'b0}};
            end else if (starve_cnt_r != CNT_MAX) begin
                starve_cnt_r <= starve_cnt_r + CNT_W'(1'b1);
            end else begin
                starve_cnt_r <= starve_cnt_r;
            end
            bubble_r <= (starve_cnt_r >= LIMIT) && !pop_s;
        end
    end

    assign bus.mdu_ready_out  = ready_s;
    assign bus.rf_we_out      = we_s;
    assign bus.rf_waddr_out   = waddr_s;
    assign bus.rf_wdata_out   = wdata_s;
    assign bus.bubble_req_out = bubble_r;
    assign bus.fifo_count_out = count_r;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a queue-based reference model.
module tb_wb_port_arbiter;
    localparam int DEPTH = 2;
    localparam int LIMIT = 4;
`ifdef WB_MDU_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    wb_port_arbiter_if #(.DEPTH(DEPTH)) bus ();

    wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT), .CNT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model: pending MDU results in acceptance order, and how many cycles the head was denied
    logic [36:0] q[$];
    int          denied   = 0;
    bit          last_acc = 1'b0;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_now();
        bit          pw;
        logic        ew;
        logic [4:0]  ea;
        logic [31:0] ed;
        pw = bus.pipe_RegWrite_in && (bus.pipe_DestReg_in != 5'd0);
        ew = 1'b0; ea = 5'd0; ed = 32'd0;
        if (pw) begin
            ew = 1'b1; ea = bus.pipe_DestReg_in; ed = bus.pipe_data_in;
        end else if (q.size() > 0) begin
            ew = 1'b1; ea = q[0][36:32]; ed = q[0][31:0];
        end else if (BYP && bus.mdu_valid_in && (bus.mdu_DestReg_in != 5'd0)) begin
            ew = 1'b1; ea = bus.mdu_DestReg_in; ed = bus.mdu_data_in;
        end
        chk("rf_we", bus.rf_we_out, ew);
        chk("rf_waddr", bus.rf_waddr_out, ea);
        chk("rf_wdata", bus.rf_wdata_out, ed);
        chk("mdu_ready", bus.mdu_ready_out, q.size() < DEPTH);
        chk("fifo_count", bus.fifo_count_out, q.size());
        chk("bubble_req", bus.bubble_req_out, (q.size() > 0) && (denied > LIMIT));
    endtask

    task automatic advance();
        bit          pw, pop, acc, byp;
        logic [4:0]  md;
        logic [31:0] mdat;
        pw   = bus.pipe_RegWrite_in && (bus.pipe_DestReg_in != 5'd0);
        pop  = !pw && (q.size() > 0);
        acc  = bus.mdu_valid_in && (q.size() < DEPTH);
        byp  = BYP && !pw && (q.size() == 0) && bus.mdu_valid_in && (bus.mdu_DestReg_in != 5'd0);
        md   = bus.mdu_DestReg_in;
        mdat = bus.mdu_data_in;
        @(posedge clk);
        if (pop) begin
            void'(q.pop_front());
            denied = 0;
        end else if ((q.size() > 0) && pw) begin
            denied++;
        end
        if (acc && (md != 5'd0) && !byp) q.push_back({md, mdat});
        last_acc = acc;
        #1;
    endtask

    task automatic cyc();
        check_now();
        advance();
    endtask

    task automatic drive_pipe(input logic we, input logic [4:0] d, input logic [31:0] v);
        bus.pipe_RegWrite_in = we; bus.pipe_DestReg_in = d; bus.pipe_data_in = v;
    endtask

    task automatic drive_mdu(input logic vld, input logic [4:0] d, input logic [31:0] v);
        bus.mdu_valid_in = vld; bus.mdu_DestReg_in = d; bus.mdu_data_in = v;
    endtask

    initial begin
        drive_pipe(1'b0, 5'd0, 32'd0);
        drive_mdu(1'b0, 5'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_we", bus.rf_we_out, 1'b0);
        chk("reset_ready", bus.mdu_ready_out, 1'b0);
        chk("reset_count", bus.fifo_count_out, 2'd0);
        rst = 1'b1;
        #3;
        chk("post_reset_ready", bus.mdu_ready_out, 1'b1);
        cyc();

        // Idle drain of one MDU result
        drive_mdu(1'b1, 5'd5, 32'hDEADBEEF);
        #3;
`ifdef WB_MDU_BYPASS_EN
        chk("bypass_r5_we", bus.rf_we_out, 1'b1);
        chk("bypass_r5_addr", bus.rf_waddr_out, 5'd5);
`else
        chk("drain_accept_we", bus.rf_we_out, 1'b0);
`endif
        cyc();
        drive_mdu(1'b0, 5'd0, 32'd0);
        #3;
`ifdef WB_MDU_BYPASS_EN
        chk("bypass_r5_count", bus.fifo_count_out, 2'd0);
`else
        chk("drain_we", bus.rf_we_out, 1'b1);
        chk("drain_addr", bus.rf_waddr_out, 5'd5);
        chk("drain_data", bus.rf_wdata_out, 32'hDEADBEEF);
        chk("drain_count", bus.fifo_count_out, 2'd1);
`endif
        cyc();
        #3;
        chk("drain_empty", bus.fifo_count_out, 2'd0);
        cyc();

        // Pipeline priority, backpressure and starvation
        drive_pipe(1'b1, 5'd3, 32'h0000_0333);
        drive_mdu(1'b1, 5'd7, 32'h11);
        #3; cyc();
        drive_mdu(1'b1, 5'd8, 32'h22);
        #3; cyc();
        drive_mdu(1'b0, 5'd0, 32'd0);
        #3;
        chk("bp_count", bus.fifo_count_out, 2'd2);
        chk("bp_ready", bus.mdu_ready_out, 1'b0);
        chk("bp_addr", bus.rf_waddr_out, 5'd3);
        chk("bp_bubble_early", bus.bubble_req_out, 1'b0);
        cyc();
        for (int i = 0; i < 3; i++) begin
            #3;
            chk("prio_addr", bus.rf_waddr_out, 5'd3);
            chk("prio_we", bus.rf_we_out, 1'b1);
            chk("bubble_not_yet", bus.bubble_req_out, 1'b0);
            cyc();
        end
        #3;
        chk("bubble_rise", bus.bubble_req_out, 1'b1);
        cyc();
        drive_pipe(1'b0, 5'd3, 32'h0000_0333);
        #3;
        chk("starve_pop_addr", bus.rf_waddr_out, 5'd7);
        chk("starve_pop_data", bus.rf_wdata_out, 32'h11);
        chk("starve_pop_bubble", bus.bubble_req_out, 1'b1);
        cyc();
        drive_pipe(1'b1, 5'd3, 32'h0000_0333);
        #3;
        chk("bubble_fall", bus.bubble_req_out, 1'b0);
        chk("after_pop_count", bus.fifo_count_out, 2'd1);
        cyc();

        // Pipe write to r0 leaves the port free for the head
        drive_pipe(1'b1, 5'd0, 32'hFFFF_FFFF);
        #3;
        chk("r0_pipe_addr", bus.rf_waddr_out, 5'd8);
        chk("r0_pipe_data", bus.rf_wdata_out, 32'h22);
        cyc();
        drive_pipe(1'b0, 5'd0, 32'd0);
        drive_mdu(1'b1, 5'd0, 32'h55);
        #3;
        chk("r0_mdu_ready", bus.mdu_ready_out, 1'b1);
        chk("r0_mdu_we", bus.rf_we_out, 1'b0);
        cyc();
        drive_mdu(1'b0, 5'd0, 32'd0);
        #3;
        chk("r0_mdu_count", bus.fifo_count_out, 2'd0);
        chk("r0_mdu_never", bus.rf_we_out, 1'b0);
        cyc();

        // Simultaneous push and pop at count 1
        drive_pipe(1'b1, 5'd3, 32'h0000_0444);
        drive_mdu(1'b1, 5'd10, 32'hA);
        #3; cyc();
        drive_pipe(1'b0, 5'd0, 32'd0);
        drive_mdu(1'b1, 5'd11, 32'hB);
        #3;
        chk("pp_count_before", bus.fifo_count_out, 2'd1);
        chk("pp_first_addr", bus.rf_waddr_out, 5'd10);
        cyc();
        drive_mdu(1'b0, 5'd0, 32'd0);
        #3;
        chk("pp_count_after", bus.fifo_count_out, 2'd1);
        chk("pp_second_addr", bus.rf_waddr_out, 5'd11);
        chk("pp_second_data", bus.rf_wdata_out, 32'hB);
        cyc();
        #3; cyc();
`ifdef WB_MDU_BYPASS_EN
        drive_mdu(1'b1, 5'd9, 32'h99);
        #3;
        chk("bypass_r9_we", bus.rf_we_out, 1'b1);
        chk("bypass_r9_addr", bus.rf_waddr_out, 5'd9);
        cyc();
        drive_mdu(1'b0, 5'd0, 32'd0);
        #3;
        chk("bypass_r9_count", bus.fifo_count_out, 2'd0);
        cyc();
`endif

        // Asynchronous reset with two results queued
        drive_pipe(1'b1, 5'd3, 32'h0000_0555);
        drive_mdu(1'b1, 5'd12, 32'hC);
        #3; cyc();
        drive_mdu(1'b1, 5'd13, 32'hD);
        #3; cyc();
        drive_mdu(1'b0, 5'd0, 32'd0);
        #3;
        chk("prereset_count", bus.fifo_count_out, 2'd2);
        rst = 1'b0;
        #1;
        chk("midreset_we", bus.rf_we_out, 1'b0);
        chk("midreset_ready", bus.mdu_ready_out, 1'b0);
        chk("midreset_count", bus.fifo_count_out, 2'd0);
        q.delete();
        denied = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive_pipe(1'b0, 5'd0, 32'd0);
        #3;
        chk("release_ready", bus.mdu_ready_out, 1'b1);
        chk("release_we", bus.rf_we_out, 1'b0);
        cyc();

        // Randomized traffic; the MDU holds its result until accepted
        for (int i = 0; i < 3000; i++) begin
            bus.pipe_RegWrite_in = ($urandom_range(0, 99) < 65);
            bus.pipe_DestReg_in  = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            bus.pipe_data_in     = $urandom;
            if (!bus.mdu_valid_in && ($urandom_range(0, 99) < 40)) begin
                drive_mdu(1'b1, ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom);
            end
            #3;
            cyc();
            if (last_acc) bus.mdu_valid_in = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between the MEM/WB pipeline writeback and the multi-cycle multiply/divide unit (MDU).
- Pipeline writeback always has priority.
- MDU results wait in a small FIFO and drain on free write-port cycles.
- A starvation counter requests pipeline bubbles from the hazard unit when an MDU result waits too long.

Parameters:
- DEPTH, 2: MDU result FIFO entries (power of 2, >=2).
- STARVE_LIMIT, 4: cycles a FIFO head may be denied before a bubble is requested.
- CNT_W, 3: starvation counter width; must hold STARVE_LIMIT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- pipe_RegWrite_in  in  1  MEM/WB RegWrite.
- pipe_DestReg_in  in  5  MEM/WB destination register.
- pipe_data_in  in  32  MEM/WB writeback data (post MemToReg select).
- mdu_valid_in  in  1  MDU result valid.
- mdu_DestReg_in  in  5  MDU destination register.
- mdu_data_in  in  32  MDU result.
- mdu_ready_out  out  1  arbiter can accept an MDU result this cycle.
- rf_we_out  out  1  register-file write enable.
- rf_waddr_out  out  5  register-file write address.
- rf_wdata_out  out  32  register-file write data.
- bubble_req_out  out  1  request to the hazard unit to insert a bubble.
- fifo_count_out  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (rst low, async):
  - FIFO pointers, count, starvation counter and bubble_req_out clear to 0 immediately.
  - While rst is low, rf_we_out, mdu_ready_out, rf_waddr_out and rf_wdata_out are forced to 0.
  - Reset mid-drain discards all queued MDU results.
- Pipe write valid (pw) = pipe_RegWrite_in && pipe_DestReg_in != 0. Writes to r0 are dropped and leave the port free.
- Grant, combinational, same cycle as inputs:
  - If pw: rf_* = pipe inputs. The FIFO head is held.
  - Else if FIFO non-empty: rf_* = head. Pop at next clk edge.
  - Else: rf_we_out = 0, rf_waddr_out = 0, rf_wdata_out = 0.
- Push:
  - mdu_ready_out = (count < DEPTH). It depends on count only, never on a same-cycle pop.
  - Accept on mdu_valid_in && mdu_ready_out at the clk edge.
  - Accepted results with mdu_DestReg_in == 0 are discarded and never enqueued.
  - The MDU must hold valid and data until ready.
- Count rules:
  - Push only: +1.
  - Pop only: -1.
  - Push and pop in the same cycle: unchanged, head advances, write pointer advances.
  - Pointers wrap modulo DEPTH.
- Minimum latency: an MDU result is written no earlier than the cycle after acceptance (without the optional feature).
- Starvation counter:
  - Increments (saturating at 2^CNT_W-1) each cycle the FIFO is non-empty and pw is high.
  - Clears on pop or when the FIFO is empty.
- bubble_req_out:
  - Registered; sets the cycle after counter >= STARVE_LIMIT.
  - Clears the cycle after the starved head pops.
- Ordering:
  - FIFO entries are written strictly in acceptance order.
  - No same-register WAW check; the issue scoreboard guarantees no pipe and MDU writes to the same register are outstanding together.
- fifo_count_out = count, registered.

Optional Feature:
- Macro WB_MDU_BYPASS_EN.
- Defined: when !pw, the FIFO is empty, and mdu_valid_in is high with mdu_DestReg_in != 0:
  - the MDU result drives rf_* in the same cycle;
  - it is accepted (mdu_ready_out = 1) and not enqueued, giving 0-cycle latency.
- Undefined: every MDU result passes through the FIFO, with at least 1 cycle of latency.

Test Plan:
- Reset: drive rst low mid-cycle with FIFO count 2 -> rf_we_out = 0, mdu_ready_out = 0 and fifo_count_out = 0 immediately, with no clock edge needed. After release, ready = 1.
- Idle drain: pipe idle, MDU pushes r5 = 0xDEADBEEF -> next cycle rf_we_out = 1, rf_waddr_out = 5, rf_wdata_out = 0xDEADBEEF; count returns to 0.
- Priority and backpressure:
  - Stimulus: pipe writes r3 continuously; MDU pushes r7 = 0x11 then r8 = 0x22.
  - Response: count reaches 2 and mdu_ready_out = 0.
  - Response: the pipe write to r3 is seen every cycle; no MDU write occurs.
- Starvation (STARVE_LIMIT = 4):
  - Stimulus: hold pw high with the FIFO non-empty.
  - Response: bubble_req_out rises after the 5th denied cycle.
  - Stimulus: drop pipe_RegWrite_in for 1 cycle.
  - Response: r7 = 0x11 is written, and bubble_req_out falls the next cycle.
- r0 handling:
  - Pipe write to r0 with head r8 pending -> r8 = 0x22 is written in that cycle.
  - MDU push to r0 -> accepted, count unchanged, never written.
- Simultaneous push and pop at count = 1 -> count stays 1 and entries are written in FIFO order. With WB_MDU_BYPASS_EN, an MDU push to r9 when the FIFO is empty and the pipe is idle -> same-cycle write of r9 and count stays 0.
